// File: rtl/uart_pkg.sv
// Shared UART constants and the sequencer state encoding.
package uart_pkg;

    localparam int CLKS_PER_BIT   = 10416;
    localparam int TIMEOUT_CYCLES = 12 * CLKS_PER_BIT;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SEND  = ST_SEND,
        DRAIN = ST_DRAIN
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or above rr_ptr,
// wrapping around to index 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any_req
);

    int   pos_i;
    logic found;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        pos_i      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos_i = int'(rr_ptr) + i;
            if (pos_i >= N_REQ) begin
                pos_i = pos_i - N_REQ;
            end
            if (!found && req[pos_i[PTR_W-1:0]]) begin
                found                          = 1'b1;
                winner_oh[pos_i[PTR_W-1:0]]    = 1'b1;
                winner_idx                     = pos_i[PTR_W-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte sources.
//
//   state | meaning
//   IDLE  | no owner; grant a requester once the transmitter's done is low
//   SEND  | transmit held high, waiting for clear_done or the timeout
//   DRAIN | frame finished or aborted; wait for clear_done to fall
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES,
    parameter int TO_W           = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data,
    input  logic                 tx_clear_done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int              PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             tx_transmit_q, tx_transmit_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic             terr_q, terr_d;

    logic [N_REQ-1:0] win_oh;
    logic [PTR_W-1:0] win_idx;
    logic             any_req;
    logic [PTR_W-1:0] idx_next;
    logic [7:0]       req_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .rr_ptr     (rr_q),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any_req    (any_req)
    );

    // Priority moves to the requester just after the current owner.
    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + PTR_W'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ack_d         = '0;
        tx_transmit_d = tx_transmit_q;
        tx_data_d     = tx_data_q;
        cnt_d         = cnt_q;
        rr_d          = rr_q;
        idx_d         = idx_q;
        terr_d        = terr_q;
        case (state_q)
            IDLE: begin
                // A done level still high here belongs to the previous frame.
                if (any_req && !tx_clear_done) begin
                    state_d       = SEND;
                    grant_d       = win_oh;
                    idx_d         = win_idx;
                    tx_data_d     = req_bytes[win_idx];
                    tx_transmit_d = 1'b1;
                    cnt_d         = '0;
                end
            end
            SEND: begin
                cnt_d = cnt_q + TO_W'(1);
                if (tx_clear_done) begin
                    state_d       = DRAIN;
                    tx_transmit_d = 1'b0;
                    ack_d         = grant_q;
                    rr_d          = idx_next;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort without ack, but still move past the stuck owner.
                    state_d       = DRAIN;
                    tx_transmit_d = 1'b0;
                    terr_d        = 1'b1;
                    rr_d          = idx_next;
                end
            end
            DRAIN: begin
                if (!tx_clear_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                tx_transmit_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            ack_q         <= '0;
            tx_transmit_q <= 1'b0;
            tx_data_q     <= '0;
            cnt_q         <= '0;
            rr_q          <= '0;
            idx_q         <= '0;
            terr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ack_q         <= ack_d;
            tx_transmit_q <= tx_transmit_d;
            tx_data_q     <= tx_data_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            idx_q         <= idx_d;
            terr_q        <= terr_d;
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign tx_transmit = tx_transmit_q;
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, multi-cycle corner
// sequences and random traffic, all checked against a cycle reference model
// plus a serial-line receiver on a behavioural transmitter.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int T   = 64;
    localparam int TW  = 7;
    localparam int BIT = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   ack, grant;
    logic           tx_transmit;
    logic [7:0]     tx_data;
    logic           tx_clear_done;
    logic           busy, timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T),
        .TO_W           (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .grant         (grant),
        .tx_transmit   (tx_transmit),
        .tx_data       (tx_data),
        .tx_clear_done (tx_clear_done),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural transmitter ----------------
    logic       xmit_en = 1'b0;
    logic       done_manual = 1'b0;
    logic       done_x = 1'b0;
    logic       xbusy = 1'b0;
    logic [9:0] frame = 10'h3ff;
    logic [3:0] pos = '0;
    int         bc = 0;
    int         dcnt = 0;
    int         done_len = 2;
    logic       line;

    assign tx_clear_done = xmit_en ? done_x : done_manual;
    assign line          = xbusy ? frame[pos] : 1'b1;

    // Start a frame on transmit while idle, then hold done for done_len cycles.
    always @(posedge clk) begin
        if (reset || !xmit_en) begin
            xbusy  <= 1'b0;
            done_x <= 1'b0;
            dcnt   <= 0;
        end else if (done_x) begin
            if (dcnt <= 1) done_x <= 1'b0;
            dcnt <= dcnt - 1;
        end else if (!xbusy) begin
            if (tx_transmit) begin
                xbusy <= 1'b1;
                frame <= {1'b1, tx_data, 1'b0};
                pos   <= '0;
                bc    <= 0;
            end
        end else if (bc == BIT - 1) begin
            bc <= 0;
            if (pos == 4'd9) begin
                xbusy  <= 1'b0;
                done_x <= 1'b1;
                dcnt   <= done_len;
            end else begin
                pos <= pos + 4'd1;
            end
        end else begin
            bc <= bc + 1;
        end
    end

    // ---------------- serial receiver ----------------
    logic       line_prev = 1'b1;
    logic       rx_act = 1'b0;
    int         rx_t = 0;
    logic [9:0] rx_frame = '0;
    logic [9:0] rx_last = '0;

    // Detect the start bit edge and sample each bit mid-way.
    always @(posedge clk) begin
        if (reset) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (!line && line_prev) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % BIT == BIT / 2) begin
                rx_frame[rx_t / BIT] = line;
                if (rx_t / BIT == 9) begin
                    rx_last = rx_frame;
                    rx_act  = 1'b0;
                end
            end
        end
        line_prev = line;
    end

    // ---------------- reference model ----------------
    logic [N-1:0]   req_s;
    logic [8*N-1:0] data_s;
    logic           done_s, rst_s, xe_s;
    logic           seen = 1'b0;

    int           m_phase = 0;   // 0 free, 1 waiting for done, 2 waiting for done low
    int           m_ptr = 0;
    int           m_w = 0;
    int           m_k = 0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_ack = '0;
    logic         e_tx = 1'b0;
    logic         e_terr = 1'b0;
    logic [7:0]   e_data = '0;
    int           n_acks = 0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    // Capture what the DUT sees at each rising edge.
    always @(posedge clk) begin
        req_s  = req;
        data_s = req_data;
        done_s = tx_clear_done;
        rst_s  = reset;
        xe_s   = xmit_en;
        seen   = 1'b1;
    end

    // Advance the model by one edge and compare every output.
    always @(negedge clk) begin
        if (seen) begin
            if (rst_s) begin
                m_phase = 0; m_ptr = 0; m_w = 0; m_k = 0;
                e_grant = '0; e_ack = '0; e_tx = 1'b0; e_terr = 1'b0; e_data = '0;
            end else begin
                e_ack = '0;
                case (m_phase)
                    0: if (req_s != 0 && !done_s) begin
                        m_w = pick(req_s, m_ptr);
                        e_grant = '0;
                        e_grant[m_w] = 1'b1;
                        e_data = data_s[8*m_w +: 8];
                        e_tx = 1'b1;
                        m_k = 0;
                        m_phase = 1;
                    end
                    1: if (done_s) begin
                        e_tx = 1'b0;
                        e_ack[m_w] = 1'b1;
                        m_ptr = (m_w + 1) % N;
                        m_phase = 2;
                        n_acks++;
                    end else if (m_k == T - 1) begin
                        e_tx = 1'b0;
                        e_terr = 1'b1;
                        m_ptr = (m_w + 1) % N;
                        m_phase = 2;
                    end else begin
                        m_k++;
                    end
                    default: if (!done_s) begin
                        e_grant = '0;
                        m_phase = 0;
                    end
                endcase
            end
            chk("grant", grant, e_grant);
            chk("ack", ack, e_ack);
            chk("tx_transmit", tx_transmit, e_tx);
            chk("tx_data", tx_data, e_data);
            chk("busy", busy, m_phase != 0);
            chk("timeout_err", timeout_err, e_terr);
            if (e_ack != 0 && xe_s) chk("serial_frame", rx_last, {1'b1, e_data, 1'b0});
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [N-1:0] rq;
        logic [31:0]  data;
        logic [N-1:0] exp_grant;
        logic [7:0]   exp_byte;
    } vec_t;

    vec_t tbl[8];

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 grant!=0, 1 ack!=0, 2 grant==0, 3 busy==0
    task automatic wait_for(input string name, input int kind, input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            case (kind)
                0: ok = (grant != 0);
                1: ok = (ack != 0);
                2: ok = (grant == 0);
                default: ok = !busy;
            endcase
            if (ok) break;
            tick();
        end
        if (!ok) bound_fail(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic saw_ack;
        int   n;

        tbl[0] = '{4'b0001, 32'hA3A2A155, 4'b0001, 8'h55};
        tbl[1] = '{4'b1111, 32'hA3A2A1A0, 4'b0010, 8'hA1};
        tbl[2] = '{4'b0101, 32'hA3A2A1A0, 4'b0100, 8'hA2};
        tbl[3] = '{4'b1001, 32'hA3A2A1A0, 4'b1000, 8'hA3};
        tbl[4] = '{4'b1001, 32'hA3A2A1A0, 4'b0001, 8'hA0};
        tbl[5] = '{4'b1101, 32'hA3A2A1A0, 4'b0100, 8'hA2};
        tbl[6] = '{4'b0011, 32'hA3A2A1A0, 4'b0001, 8'hA0};
        tbl[7] = '{4'b0010, 32'hA3A2A1A0, 4'b0010, 8'hA1};

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("reset_grant", grant, 0);
        chk("reset_ack", ack, 0);
        chk("reset_tx", tx_transmit, 0);
        chk("reset_data", tx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_terr", timeout_err, 0);

        // Vector table: one transaction per entry, priority carried across.
        xmit_en  = 1'b1;
        done_len = 2;
        tick(2);
        for (int v = 0; v < 8; v++) begin
            req_data = tbl[v].data;
            req      = tbl[v].rq;
            tick();
            chk("tbl_grant", grant, tbl[v].exp_grant);
            chk("tbl_tx", tx_transmit, 1);
            chk("tbl_byte", tx_data, tbl[v].exp_byte);
            wait_for("tbl_ack_wait", 1, 200);
            chk("tbl_ack", ack, tbl[v].exp_grant);
            chk("tbl_byte_held", tx_data, tbl[v].exp_byte);
            req = '0;
            tick();
            chk("tbl_ack_pulse", ack, 0);
            wait_for("tbl_idle_wait", 3, 50);
        end

        // Reset during SEND.
        req_data = 32'hA3A2A1A0;
        req      = 4'b0100;
        tick();
        chk("rst_pre_grant", grant, 4'b0100);
        tick(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = '0;
        chk("rst_grant", grant, 0);
        chk("rst_tx", tx_transmit, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        tick(2);

        // Fairness: all requests held, pointer restarts at 0 after reset.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for("fair_grant_wait", 0, 50);
            chk("fair_grant", grant, 4'b0001 << (k % 4));
            chk("fair_byte", tx_data, 8'hA0 + 8'(k % 4));
            wait_for("fair_ack_wait", 1, 200);
            if (k == 4) req = '0;
            tick();
            wait_for("fair_release_wait", 2, 50);
        end
        wait_for("fair_idle_wait", 3, 50);

        // Stale done in IDLE blocks the grant until it falls.
        xmit_en     = 1'b0;
        done_manual = 1'b1;
        req         = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("stale_grant", grant, 0);
        end
        done_manual = 1'b0;
        tick();
        chk("stale_release_grant", grant, 4'b0010);
        chk("stale_release_tx", tx_transmit, 1);
        tick(3);
        done_manual = 1'b1;
        wait_for("stale_ack_wait", 1, 10);
        chk("stale_ack", ack, 4'b0010);
        req = '0;
        tick(2);
        chk("stale_drain_grant", grant, 4'b0010);
        done_manual = 1'b0;
        wait_for("stale_idle_wait", 3, 10);

        // Timeout with a transmitter that never finishes.
        req = 4'b0001;
        tick();
        chk("to_grant", grant, 4'b0001);
        saw_ack = 1'b0;
        n = 0;
        while (tx_transmit && n < T + 10) begin
            tick();
            n++;
            if (ack != 0) saw_ack = 1'b1;
        end
        req = '0;
        chk("to_latency", n, T);
        chk("to_terr", timeout_err, 1);
        tick();
        if (ack != 0) saw_ack = 1'b1;
        chk("to_no_ack", saw_ack, 0);
        chk("to_busy", busy, 0);
        tick(3);
        chk("to_terr_sticky", timeout_err, 1);

        // Random traffic against the reference model.
        xmit_en = 1'b1;
        tick(2);
        n = n_acks;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom % 4 == 0) req_data[8*i +: 8] = 8'($urandom);
                    else req[i] = 1'b0;
                end else if (req[i] && grant[i] && $urandom % 60 == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !grant[i] && $urandom % 6 == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
            done_len = $urandom_range(2, BIT);
            tick();
        end
        req = '0;
        tick(80);
        chk("random_progress", (n_acks - n) > 20, 1);
        chk("random_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
